// File: rtl/trace_packer.sv
// trace_packer
//   Captures the oscillator state (xn, yn, zn) on sample strobes, keeps one
//   strobe out of every Decim, and buffers the kept samples in a small FIFO.
//   Each buffered sample is sent as a byte frame over a valid/ready handshake:
//   a Header byte, then x, y and z, each most-significant byte first.
//
// Ports
//   clk_i           system clock
//   rst_i           asynchronous reset, active-high
//   enable_i        capture enable (0 stops new pushes; the FIFO still drains)
//   sample_valid_i  one-cycle strobe qualifying xn_i/yn_i/zn_i
//   xn_i/yn_i/zn_i  signed oscillator state, Width bits each
//   byte_o          output byte
//   byte_valid_o    byte_o is valid
//   byte_ready_i    sink accepts byte_o
//   clear_i         synchronous clear of overflow_o and dropped_o
//   overflow_o      sticky flag: at least one kept sample was dropped
//   dropped_o       saturating count of dropped samples
//   level_o         FIFO occupancy
module trace_packer #(
  parameter int         Width  = 16,
  parameter int         Depth  = 16,
  parameter int         Decim  = 8,
  parameter logic [7:0] Header = 8'hA5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     sample_valid_i,
  input  logic signed [Width-1:0]  xn_i,
  input  logic signed [Width-1:0]  yn_i,
  input  logic signed [Width-1:0]  zn_i,
  output logic [7:0]               byte_o,
  output logic                     byte_valid_o,
  input  logic                     byte_ready_i,
  input  logic                     clear_i,
  output logic                     overflow_o,
  output logic [15:0]              dropped_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int Bpw = Width / 8;
  localparam int NB  = 3 * Bpw;
  localparam int AW  = $clog2(Depth);
  localparam int DW  = (Decim > 1) ? $clog2(Decim) : 1;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int FW  = 3 * Width;

  localparam logic [DW-1:0] DLAST  = DW'(Decim - 1);
  localparam logic [BW-1:0] BLAST  = BW'(NB - 1);
  localparam logic [AW:0]   LFULL  = (AW + 1)'(Depth);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t          state;
  state_t          next_state;
  logic [DW-1:0]   dcnt;
  logic            candidate;
  logic            push;
  logic            pop;
  logic            drop;
  logic            full;
  logic            empty;
  logic            handshake;
  logic            last_byte;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;
  logic [FW-1:0]   mem [Depth];
  logic [FW-1:0]   fr;
  logic [BW-1:0]   bidx;
  logic [7:0]      data_byte;

  assign candidate = enable_i && sample_valid_i && (dcnt == '0);
  assign full      = (count == LFULL);
  assign empty     = (count == '0);
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push      = candidate && (!full || pop);
  assign drop      = candidate && !push;
  assign handshake = byte_valid_o && byte_ready_i;
  assign last_byte = (bidx == BLAST);
  assign level_o   = count;

  // Decimation counter: cleared while capture is disabled so the first
  // strobe after enabling is always kept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dcnt <= '0;
    end else if (!enable_i) begin
      dcnt <= '0;
    end else if (sample_valid_i) begin
      dcnt <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
    end
  end

  // FIFO storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr] <= {xn_i, yn_i, zn_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Drop bookkeeping; clear wins over a drop in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
      dropped_o  <= '0;
    end else if (clear_i) begin
      overflow_o <= 1'b0;
      dropped_o  <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (dropped_o != 16'hFFFF) begin
        dropped_o <= dropped_o + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      fr    <= '0;
      bidx  <= '0;
    end else begin
      state <= next_state;
      if (pop) begin
        fr <= mem[rptr];
      end
      if (state == HDR && handshake) begin
        bidx <= '0;
      end else if (state == DATA && handshake) begin
        bidx <= bidx + 1'b1;
      end
    end
  end

  // Byte bidx of the frame register, counting from the most significant byte.
  always_comb begin
    data_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (bidx == BW'(i)) begin
        data_byte = fr[(NB-1-i)*8 +: 8];
      end
    end
  end

  // Outputs depend only on state, so byte_valid_o never follows byte_ready_i
  // combinationally and an asynchronous reset drops it immediately.
  always_comb begin
    next_state   = state;
    pop          = 1'b0;
    byte_valid_o = 1'b0;
    byte_o       = '0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = HDR;
        end
      end
      HDR: begin
        byte_valid_o = 1'b1;
        byte_o       = Header;
        if (byte_ready_i) begin
          next_state = DATA;
        end
      end
      DATA: begin
        byte_valid_o = 1'b1;
        byte_o       = data_byte;
        if (byte_ready_i && last_byte) begin
          if (!empty) begin
            pop        = 1'b1;
            next_state = HDR;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trace_packer.sv
// Testbench for trace_packer. Two instances share the sample inputs: one with
// Decim=1 (latency, backpressure, overflow, enable gating) and one with
// Decim=8 (decimation and counter restart). Expected byte streams come from a
// frame-level model: every kept sample appends Header, x, y, z bytes.
module tb_trace_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sv = 1'b0;
  logic [15:0] xn = '0;
  logic [15:0] yn = '0;
  logic [15:0] zn = '0;
  logic        en = 1'b0;
  logic        enDec = 1'b0;
  logic        ready = 1'b0;
  logic        readyDec = 1'b1;
  logic        clear = 1'b0;

  logic [7:0]  by;
  logic        bv;
  logic        ov;
  logic [15:0] dr;
  logic [4:0]  lvl;
  logic [7:0]  byDec;
  logic        bvDec;
  logic        ovDec;
  logic [15:0] drDec;
  logic [4:0]  lvlDec;

  int passed = 0;
  int failed = 0;
  int total = 0;
  int room = 1000000;
  int sinceDec = 0;
  bit randReady = 1'b0;

  logic [7:0] gotQ[$];
  logic [7:0] expQ[$];
  logic [7:0] gotDecQ[$];
  logic [7:0] expDecQ[$];

  trace_packer #(.Width(16), .Depth(16), .Decim(1), .Header(8'hA5)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .sample_valid_i(sv),
    .xn_i(xn), .yn_i(yn), .zn_i(zn),
    .byte_o(by), .byte_valid_o(bv), .byte_ready_i(ready),
    .clear_i(clear), .overflow_o(ov), .dropped_o(dr), .level_o(lvl)
  );

  trace_packer #(.Width(16), .Depth(16), .Decim(8), .Header(8'hA5)) dutDec (
    .clk_i(clk), .rst_i(rst), .enable_i(enDec), .sample_valid_i(sv),
    .xn_i(xn), .yn_i(yn), .zn_i(zn),
    .byte_o(byDec), .byte_valid_o(bvDec), .byte_ready_i(readyDec),
    .clear_i(clear), .overflow_o(ovDec), .dropped_o(drDec), .level_o(lvlDec)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Collects every accepted byte of both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (bv && ready) gotQ.push_back(by);
    if (bvDec && readyDec) gotDecQ.push_back(byDec);
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) begin
      ready    = ($urandom % 4) != 0;
      readyDec = ($urandom % 4) != 0;
    end
  endtask

  task automatic expectFrame(input bit toDec, input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] z);
    logic [7:0] f[7];
    f = '{8'hA5, x[15:8], x[7:0], y[15:8], y[7:0], z[15:8], z[7:0]};
    for (int i = 0; i < 7; i++) begin
      if (toDec) expDecQ.push_back(f[i]);
      else expQ.push_back(f[i]);
    end
  endtask

  // One-cycle strobe; the model decides which instance keeps the sample.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    xn = x; yn = y; zn = z; sv = 1'b1;
    if (en && room > 0) begin
      expectFrame(1'b0, x, y, z);
      room--;
    end
    if (enDec) begin
      if (sinceDec % 8 == 0) expectFrame(1'b1, x, y, z);
      sinceDec++;
    end
    tick();
    sv = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      @(negedge clk);
      if (!bv && !bvDec && lvl == 0 && lvlDec == 0) done = 1'b1;
    end
    checkOutput(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic checkStream(input string tag, input bit dec);
    logic [7:0] g[$];
    logic [7:0] e[$];
    if (dec) begin g = gotDecQ; e = expDecQ; end
    else begin g = gotQ; e = expQ; end
    checkOutput($sformatf("%s_len", tag), g.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      checkOutput($sformatf("%s_byte%0d", tag, i), (i < g.size()) ? {24'd0, g[i]} : 32'hDEAD,
                  {24'd0, e[i]});
    end
    if (dec) begin gotDecQ.delete(); expDecQ.delete(); end
    else begin gotQ.delete(); expQ.delete(); end
  endtask

  initial begin
    logic [7:0] lat[7];
    lat = '{8'hA5, 8'h12, 8'h34, 8'hFE, 8'hDC, 8'h00, 8'h01};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", {31'd0, bv}, 32'd0);
    checkOutput("rst_byte", {24'd0, by}, 32'd0);
    checkOutput("rst_level", {27'd0, lvl}, 32'd0);
    checkOutput("rst_overflow", {31'd0, ov}, 32'd0);
    checkOutput("rst_dropped", {16'd0, dr}, 32'd0);
    rst = 1'b0;
    tick();

    // Single sample latency: header two cycles after the strobe
    en = 1'b1; ready = 1'b1;
    tick();
    applyStimulus(16'h1234, 16'hFEDC, 16'h0001);
    @(negedge clk);
    checkOutput("lat_k1_valid", {31'd0, bv}, 32'd0);
    checkOutput("lat_k1_level", {27'd0, lvl}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      @(negedge clk);
      checkOutput($sformatf("lat_valid%0d", i), {31'd0, bv}, 32'd1);
      checkOutput($sformatf("lat_byte%0d", i), {24'd0, by}, {24'd0, lat[i]});
    end
    tick();
    @(negedge clk);
    checkOutput("lat_end_valid", {31'd0, bv}, 32'd0);
    drain("lat_drain");
    checkStream("lat", 1'b0);

    // Reset in the middle of a frame with one sample queued
    tick();
    applyStimulus(16'h1111, 16'h2222, 16'h3333);
    applyStimulus(16'h4444, 16'h5555, 16'h6666);
    tick();
    tick();
    @(negedge clk);
    checkOutput("mid_valid_before", {31'd0, bv}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_valid_async", {31'd0, bv}, 32'd0);
    checkOutput("mid_level_async", {27'd0, lvl}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    gotQ.delete(); expQ.delete(); gotDecQ.delete(); expDecQ.delete();
    sinceDec = 0;
    applyStimulus(16'hA1B2, 16'hC3D4, 16'hE5F6);
    drain("mid_drain");
    checkStream("mid_fresh", 1'b0);

    // Backpressure during DATA: the low byte of x is held for five cycles
    tick();
    applyStimulus(16'h9A7C, 16'h0F0E, 16'h8001);
    tick(); tick(); tick();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_valid%0d", i), {31'd0, bv}, 32'd1);
      checkOutput($sformatf("bp_byte%0d", i), {24'd0, by}, 32'h7C);
      tick();
    end
    ready = 1'b1;
    drain("bp_drain");
    checkStream("bp", 1'b0);

    // Overflow with a stalled sink: 1 in the frame register + 16 queued kept
    ready = 1'b0;
    room = 17;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom));
    end
    tick();
    @(negedge clk);
    checkOutput("ovf_level", {27'd0, lvl}, 32'd16);
    checkOutput("ovf_dropped", {16'd0, dr}, 32'd3);
    checkOutput("ovf_flag", {31'd0, ov}, 32'd1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    checkOutput("clr_dropped", {16'd0, dr}, 32'd0);
    checkOutput("clr_flag", {31'd0, ov}, 32'd0);
    checkOutput("clr_level", {27'd0, lvl}, 32'd16);
    room = 1000000;
    ready = 1'b1;
    drain("ovf_drain");
    checkStream("ovf", 1'b0);

    // Enable gating: disable mid-frame with two queued, then re-enable
    tick();
    applyStimulus(16'h0101, 16'h0202, 16'h0303);
    applyStimulus(16'h0404, 16'h0505, 16'h0606);
    applyStimulus(16'h0707, 16'h0808, 16'h0909);
    @(negedge clk);
    checkOutput("gate_level", {27'd0, lvl}, 32'd2);
    checkOutput("gate_busy", {31'd0, bv}, 32'd1);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'hBAD0 + 16'(i), 16'hBAD0, 16'hBAD0);
      @(negedge clk);
      checkOutput($sformatf("gate_nopush%0d", i), {31'd0, lvl <= 5'd2}, 32'd1);
    end
    drain("gate_drain");
    checkStream("gate", 1'b0);
    en = 1'b1;
    tick();
    applyStimulus(16'h7777, 16'h8888, 16'h9999);
    drain("reen_drain");
    checkStream("reen", 1'b0);

    // Decimation by 8: 24 strobes every other cycle keep samples 0, 8, 16
    en = 1'b0;
    enDec = 1'b1;
    sinceDec = 0;
    tick();
    for (int i = 0; i < 24; i++) begin
      applyStimulus(16'(i), 16'(i), 16'(i));
      tick();
    end
    drain("dec_drain");
    checkOutput("dec_bytes", gotDecQ.size(), 32'd21);
    checkOutput("dec_overflow", {31'd0, ovDec}, 32'd0);
    checkStream("dec", 1'b1);

    // Counter restarts at zero after a one-cycle disable
    applyStimulus(16'd100, 16'd100, 16'd100);
    applyStimulus(16'd101, 16'd101, 16'd101);
    applyStimulus(16'd102, 16'd102, 16'd102);
    enDec = 1'b0;
    sinceDec = 0;
    tick();
    enDec = 1'b1;
    applyStimulus(16'd103, 16'd103, 16'd103);
    applyStimulus(16'd104, 16'd104, 16'd104);
    drain("dcnt_drain");
    checkStream("dcnt", 1'b1);

    // Random samples, random sink readiness, both instances capturing
    en = 1'b1;
    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(9, 19)) tick();
    end
    drain("rnd_drain");
    checkOutput("rnd_overflow", {31'd0, ov}, 32'd0);
    checkOutput("rnd_overflow_dec", {31'd0, ovDec}, 32'd0);
    checkStream("rnd", 1'b0);
    checkStream("rnd_dec", 1'b1);
    randReady = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
